// File: rtl/arith_pkg.sv
// arith_pkg: shared arithmetic constants and segment-count helper
// for the segmented adder family.
package arith_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Returns 0 when WIDTH is not a whole number of segments so callers can reject it.
    function automatic int calc_nseg(input int width, input int seg_w);
        return (seg_w > 0 && width % seg_w == 0) ? width / seg_w : 0;
    endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// adder_seg_stage: one SEG_W-bit slice of the segmented adder with carry,
// skew and valid registers; operands arrive LSB-aligned on the current segment.
module adder_seg_stage #(
    parameter int SEG_W = 8,
    parameter int UP_W  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [SEG_W+UP_W-1:0] i_a,
    input  logic [SEG_W+UP_W-1:0] i_b,
    input  logic                  i_c,
    output logic                  o_valid,
    output logic [SEG_W+UP_W-1:0] o_a,
    output logic [SEG_W+UP_W-1:0] o_b,
    output logic                  o_c,
    output logic                  o_cm
);
    localparam int W = SEG_W + UP_W;

    logic [SEG_W:0] w_sum;
    logic           w_cm;
    logic           r_v;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_c;
    logic           r_cm;

    assign w_sum = {1'b0, i_a[SEG_W-1:0]} + {1'b0, i_b[SEG_W-1:0]} + {{SEG_W{1'b0}}, i_c};
    assign w_cm  = i_a[SEG_W-1] ^ i_b[SEG_W-1] ^ w_sum[SEG_W-1];

    // The sum segment enters at the top of r_a while unprocessed a shifts down,
    // so after the last stage r_a holds the full result in bit order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v  <= 1'b0;
            r_a  <= '0;
            r_b  <= '0;
            r_c  <= 1'b0;
            r_cm <= 1'b0;
        end else if (i_en) begin
            r_v  <= i_valid;
            r_a  <= (i_a >> SEG_W) | (W'(w_sum[SEG_W-1:0]) << UP_W);
            r_b  <= i_b >> SEG_W;
            r_c  <= w_sum[SEG_W];
            r_cm <= w_cm;
        end
    end

    assign o_valid = r_v;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_c     = r_c;
    assign o_cm    = r_cm;

endmodule

// File: rtl/pipelined_adder_seg.sv
// pipelined_adder_seg: segmented pipelined add/sub with valid/ready flow control,
// one segment resolved per stage, NSEG-cycle latency.
module pipelined_adder_seg
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    if (NSEG == 0) begin : g_bad_width
        $fatal(1, "pipelined_adder_seg: WIDTH must be a nonzero multiple of SEG_W");
    end

    logic             w_adv;
    logic             w_v [NSEG+1];
    logic             w_c [NSEG+1];
    logic             w_m [NSEG+1];
    logic [WIDTH-1:0] w_a [NSEG+1];
    logic [WIDTH-1:0] w_b [NSEG+1];

    // Whole pipe advances together; a stalled output freezes every stage.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_v[0]   = in_valid & w_adv;
    assign w_a[0]   = a;
    assign w_b[0]   = (sub == ADD) ? b : ~b;
    assign w_c[0]   = (sub == SUB) ? ~cin : cin;
    assign w_m[0]   = 1'b0;

    for (genvar k = 0; k < NSEG; k++) begin : g_st
        adder_seg_stage #(
            .SEG_W(SEG_W),
            .UP_W (WIDTH - SEG_W)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_adv),
            .i_valid(w_v[k]),
            .i_a    (w_a[k]),
            .i_b    (w_b[k]),
            .i_c    (w_c[k]),
            .o_valid(w_v[k+1]),
            .o_a    (w_a[k+1]),
            .o_b    (w_b[k+1]),
            .o_c    (w_c[k+1]),
            .o_cm   (w_m[k+1])
        );
    end

    assign out_valid = w_v[NSEG];
    assign s         = w_a[NSEG];
    assign cout      = w_c[NSEG];
    assign ovf       = w_c[NSEG] ^ w_m[NSEG];

endmodule
